cache_mem_responder: RTL and testbench

Main-memory responder on the far side of the cache's line-fill/writeback port. It accepts one line request at a time from the cache controller, models a fixed access latency, then returns or absorbs a line as a burst of word beats. In the cache test top it sits between the cache and the board clock, standing in for DRAM so the cache can be exercised standalone on the DE3 and in simulation.

---
 rtl/cache_mem_responder.sv | 157 +++++++++++++++
 tb/tb_cache_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Main-memory stand-in behind the cache line-fill/writeback port: one line request at a time,
// fixed latency, word-beat bursts. Optional line counters built when CACHE_MEM_RESP_STATS_EN is defined.
module cache_mem_responder #(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 8
) (
   input  logic                  phi,
   input  logic                  reset_in,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [DEPTH_LOG2-1:0] req_addr,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WORD_W-1:0]     wr_data,
   output logic                  wr_done,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic [WORD_W-1:0]     rd_data,
   output logic [15:0]           stat_reads,
   output logic [15:0]           stat_writes,
   output logic [2:0]            state_dbg
);

   // Handshakes: req and wr transfer on a cycle where valid and ready are both high at the
   // rising edge; ready never depends on valid. rd_valid has no backpressure.

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int LINE_W = DEPTH_LOG2 - BEAT_W;
   localparam int CNT_W  = $clog2(LATENCY + 1);
   localparam int DEPTH  = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_BURST = 3'd1,
      WAIT     = 3'd2,
      RD_BURST = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                write_q, write_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   rd_data_q;
   logic                last_beat;
   logic                wr_fire;
   logic [DEPTH_LOG2-1:0] rd_idx;

   // Zero at time zero only; reset leaves the contents alone.
   logic [WORD_W-1:0] mem [0:DEPTH-1] = '{default: '0};

   assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));
   assign wr_fire   = (state_q == WR_BURST) && wr_valid;
   assign rd_idx    = {line_q, beat_d};

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      write_d = write_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               line_d  = req_addr[DEPTH_LOG2-1:BEAT_W];
               write_d = req_write;
               beat_d  = '0;
               if (req_write) begin
                  state_d = WR_BURST;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY);
               end
            end
         end
         WR_BURST: begin
            if (wr_valid) begin
               beat_d = beat_q + BEAT_W'(1);
               if (last_beat) begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY);
                  beat_d  = '0;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = write_q ? DONE : RD_BURST;
               beat_d  = '0;
            end
         end
         RD_BURST: begin
            beat_d = beat_q + BEAT_W'(1);
            if (last_beat) state_d = IDLE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge phi or posedge reset_in) begin
      if (reset_in) begin
         state_q   <= IDLE;
         line_q    <= '0;
         write_q   <= 1'b0;
         beat_q    <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         write_q   <= write_d;
         beat_q    <= beat_d;
         cnt_q     <= cnt_d;
         // Fetch the beat one cycle ahead so rd_data is a plain register during the burst.
         rd_data_q <= (state_d == RD_BURST) ? mem[rd_idx] : '0;
      end
   end

   always_ff @(posedge phi) begin
      if (wr_fire) mem[{line_q, beat_q}] <= wr_data;
   end

   assign req_ready = (state_q == IDLE);
   assign wr_ready  = (state_q == WR_BURST);
   assign wr_done   = (state_q == DONE);
   assign rd_valid  = (state_q == RD_BURST);
   assign rd_last   = (state_q == RD_BURST) && last_beat;
   assign rd_data   = rd_data_q;
   assign state_dbg = state_q;

`ifdef CACHE_MEM_RESP_STATS_EN
   logic [15:0] stat_reads_q, stat_writes_q;

   always_ff @(posedge phi or posedge reset_in) begin
      if (reset_in) begin
         stat_reads_q  <= '0;
         stat_writes_q <= '0;
      end else begin
         if (rd_last && (stat_reads_q != 16'hFFFF)) stat_reads_q <= stat_reads_q + 16'd1;
         if (wr_done && (stat_writes_q != 16'hFFFF)) stat_writes_q <= stat_writes_q + 16'd1;
      end
   end

   assign stat_reads  = stat_reads_q;
   assign stat_writes = stat_writes_q;
`else
   assign stat_reads  = '0;
   assign stat_writes = '0;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: reset values, write/read latency and data, address wrap,
// busy-ignore, reset mid-writeback and line counters (compile with CACHE_MEM_RESP_STATS_EN to build them).
module tb_cache_mem_responder;

   localparam int WORD_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int DEPTH_LOG2 = 10;
   localparam int LATENCY    = 8;
   localparam int BUDGET     = 50;

   logic                  phi = 1'b0;
   logic                  reset_in;
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [DEPTH_LOG2-1:0] req_addr;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [WORD_W-1:0]     wr_data;
   logic                  wr_done;
   logic                  rd_valid;
   logic                  rd_last;
   logic [WORD_W-1:0]     rd_data;
   logic [15:0]           stat_reads;
   logic [15:0]           stat_writes;
   logic [2:0]            state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   cache_mem_responder #(
      .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
   ) dut (
      .phi(phi), .reset_in(reset_in),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
      .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
      .stat_reads(stat_reads), .stat_writes(stat_writes), .state_dbg(state_dbg)
   );

   // clock
   always #5 phi = ~phi;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one edge; outputs are sampled 1ns after it
   task automatic tick();
      @(posedge phi);
      #1;
   endtask

   task automatic do_write(input logic [DEPTH_LOG2-1:0] addr, input logic [3:0][31:0] d,
                           input bit junk_in_wait);
      int k;
      req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
      check_eq("wr_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      check_eq("wr_ready_burst", 32'(wr_ready), 32'd1);
      for (int b = 0; b < LINE_WORDS; b++) begin
         wr_valid = 1'b1; wr_data = d[b];
         tick();
      end
      if (junk_in_wait) begin
         wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
      end else begin
         wr_valid = 1'b0;
      end
      check_eq("wr_ready_wait", 32'(wr_ready), 32'd0);
      k = 0;
      while (!wr_done && k < BUDGET) begin
         tick();
         k++;
      end
      wr_valid = 1'b0;
      check_eq("wr_done_latency", 32'(k), 32'(LATENCY));
      check_eq("wr_done_high", 32'(wr_done), 32'd1);
      tick();
      check_eq("wr_done_pulse", 32'(wr_done), 32'd0);
      check_eq("wr_idle_after", 32'(req_ready), 32'd1);
   endtask

   task automatic do_read(input logic [DEPTH_LOG2-1:0] addr, input logic [3:0][31:0] e,
                          input bit poke_req);
      int k;
      req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
      check_eq("rd_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      k = 0;
      while (!rd_valid && k < BUDGET) begin
         tick();
         k++;
      end
      check_eq("rd_latency", 32'(k), 32'(LATENCY));
      for (int b = 0; b < LINE_WORDS; b++) begin
         check_eq("rd_valid_beat", 32'(rd_valid), 32'd1);
         check_eq("rd_data_beat", rd_data, e[b]);
         check_eq("rd_last_beat", 32'(rd_last), (b == LINE_WORDS - 1) ? 32'd1 : 32'd0);
         check_eq("rd_busy_ready", 32'(req_ready), 32'd0);
         if (poke_req && b == 1) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h100;
         end
         tick();
      end
      req_valid = 1'b0;
      check_eq("rd_valid_after", 32'(rd_valid), 32'd0);
      check_eq("rd_idle_after", 32'(req_ready), 32'd1);
      if (poke_req) begin
         tick();
         check_eq("poke_still_idle", 32'(req_ready), 32'd1);
         check_eq("poke_no_wr_burst", 32'(wr_ready), 32'd0);
      end
   endtask

   logic [11:0] wide_addr;
   logic [15:0] exp_reads, exp_writes;

   initial begin
      reset_in = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      wr_valid = 1'b0; wr_data = '0;
      #1;
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
      check_eq("rst_wr_done", 32'(wr_done), 32'd0);
      check_eq("rst_rd_data", rd_data, 32'd0);
      check_eq("rst_rd_last", 32'(rd_last), 32'd0);
      check_eq("rst_stat_reads", 32'(stat_reads), 32'd0);
      check_eq("rst_stat_writes", 32'(stat_writes), 32'd0);
      tick(); tick();
      reset_in = 1'b0;
      tick();
      check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      check_eq("post_rst_wr_ready", 32'(wr_ready), 32'd0);
      check_eq("post_rst_wr_done", 32'(wr_done), 32'd0);

      // unaligned writeback lands on the aligned line, read back from the base
      do_write(10'h013, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
      do_read(10'h010, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);

      // 0xBFC truncates to word 0x3FC
      wide_addr = 12'hBFC;
      do_write(wide_addr[9:0], {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
      do_read(wide_addr[9:0], {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
      do_read(10'h3FC, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);

      // busy ignore: request during read burst, write beats during WAIT
      do_read(10'h010, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
      do_write(10'h020, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b1);
      do_read(10'h020, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b0);

      // reset after two beats of a writeback
      do_write(10'h030, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h031;
      tick();
      req_valid = 1'b0;
      wr_valid = 1'b1; wr_data = 32'hD0;
      tick();
      wr_data = 32'hD1;
      tick();
      wr_valid = 1'b0;
      reset_in = 1'b1;
      #1;
      check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
      check_eq("midrst_wr_ready", 32'(wr_ready), 32'd0);
      check_eq("midrst_stat_writes", 32'(stat_writes), 32'd0);
      tick();
      reset_in = 1'b0;
      tick();
      check_eq("midrst_idle", 32'(req_ready), 32'd1);
      do_read(10'h030, {32'hC3, 32'hC2, 32'hD1, 32'hD0}, 1'b0);

      // counters since the last reset: 3 reads, 2 writes
      do_write(10'h040, {32'h43, 32'h42, 32'h41, 32'h40}, 1'b0);
      do_read(10'h040, {32'h43, 32'h42, 32'h41, 32'h40}, 1'b0);
      do_write(10'h050, {32'h53, 32'h52, 32'h51, 32'h50}, 1'b0);
      do_read(10'h050, {32'h53, 32'h52, 32'h51, 32'h50}, 1'b0);
`ifdef CACHE_MEM_RESP_STATS_EN
      exp_reads = 16'd3; exp_writes = 16'd2;
`else
      exp_reads = 16'd0; exp_writes = 16'd0;
`endif
      check_eq("stat_reads", 32'(stat_reads), 32'(exp_reads));
      check_eq("stat_writes", 32'(stat_writes), 32'(exp_writes));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
